// File: rtl/rv32_mem_pkg.sv
// Shared definitions for the RV32 data-memory responder.
//   - funct3 encodings of the RV32I load/store width field
//   - responder FSM state encoding
//   - helpers for the alignment and illegal-funct3 checks
package rv32_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } mem_state_e;

    // funct3[1:0] encodes the access size for both loads and stores:
    // 00 byte (never misaligned), 01 halfword, 10 word.
    function automatic logic is_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] lane);
        case (funct3[1:0])
            2'b01:   return lane[0];
            2'b10:   return lane != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    // Stores only know SB/SH/SW; loads reject 011, 110 and 111.
    function automatic logic is_illegal_f3(input logic we,
                                           input logic [2:0] funct3);
        if (we)
            return funct3 > 3'd2;
        return (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    endfunction

endpackage

// File: rtl/rv32_mem_lane_align.sv
// Combinational byte-lane steering for RV32I loads and stores.
// Ports:
//   word       in  32  current RAM word at the addressed index
//   wdata      in  32  store data (low byte/halfword used for SB/SH)
//   lane       in  2   byte address bits [1:0]
//   funct3     in  3   RV32I width/sign field
//   load_data  out 32  selected lane, sign- or zero-extended
//   store_word out 32  word with the selected lanes replaced by wdata
module rv32_mem_lane_align
    import rv32_mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel  = word[{lane, 3'b000} +: 8];
        half_sel  = lane[1] ? word[31:16] : word[15:0];
        load_data = 32'h0;
        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_W:    load_data = word;
            F3_BU:   load_data = {24'h0, byte_sel};
            F3_HU:   load_data = {16'h0, half_sel};
            default: load_data = 32'h0;
        endcase
    end

    // Untouched lanes keep the old word so partial stores preserve them.
    always_comb begin
        store_word = word;
        case (funct3)
            F3_B: store_word[{lane, 3'b000} +: 8] = wdata[7:0];
            F3_H: begin
                if (lane[1])
                    store_word[31:16] = wdata[15:0];
                else
                    store_word[15:0] = wdata[15:0];
            end
            F3_W:    store_word = wdata;
            default: store_word = word;
        endcase
    end

endmodule

// File: rtl/rv32_data_mem_responder.sv
// Data-memory responder on the CPU load/store port. Accepts one request at
// a time, waits WAIT_CYCLES cycles, performs the access, then holds the
// response until the CPU takes it.
// Handshake: a request transfers on a rising edge with req_valid & req_ready;
// a response transfers on a rising edge with rsp_valid & rsp_ready. Once
// raised, rsp_valid/rsp_rdata/rsp_err stay stable until that transfer.
// Ports:
//   clk, reset_n               clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake
//   req_we, req_funct3         store flag and RV32I width field
//   req_addr, req_wdata        byte address and store data
//   rsp_valid/rsp_ready        response handshake
//   rsp_rdata, rsp_err         load result (0 for stores/errors), error flag
//   state                      current FSM state (debug)
module rv32_data_mem_responder
    import rv32_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 1
)(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [1:0]  state
);

    localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  WAIT_LOAD = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
    localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);

    mem_state_e  cur_state;
    logic [3:0]  wait_cnt;
    logic        cap_we;
    logic [2:0]  cap_funct3;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;

    logic [31:0] mem [DEPTH_WORDS];

    // The access uses the live request when it commits on the acceptance
    // edge (WAIT_CYCLES == 0) and the captured copy otherwise.
    logic             direct;
    logic             acc_we;
    logic [2:0]       acc_funct3;
    logic [31:0]      acc_addr;
    logic [31:0]      acc_wdata;
    logic             acc_err;
    logic [IDX_W-1:0] acc_idx;
    logic             commit;
    logic [31:0]      mem_word;
    logic [31:0]      load_data;
    logic [31:0]      store_word;
    logic [31:0]      rdata_next;

    always_comb begin
        direct     = (cur_state == ST_IDLE);
        acc_we     = direct ? req_we     : cap_we;
        acc_funct3 = direct ? req_funct3 : cap_funct3;
        acc_addr   = direct ? req_addr   : cap_addr;
        acc_wdata  = direct ? req_wdata  : cap_wdata;
        acc_idx    = acc_addr[IDX_W+1:2];
        acc_err    = is_misaligned(acc_funct3, acc_addr[1:0])
                   || is_illegal_f3(acc_we, acc_funct3)
                   || (acc_addr[31:2] >= DEPTH_LIM);
        commit     = ((cur_state == ST_IDLE) && req_valid && (WAIT_CYCLES == 0))
                   || ((cur_state == ST_WAIT) && (wait_cnt == 4'd0));
        mem_word   = mem[acc_idx];
        rdata_next = (acc_we || acc_err) ? 32'h0 : load_data;
    end

    rv32_mem_lane_align u_lane_align (
        .word       (mem_word),
        .wdata      (acc_wdata),
        .lane       (acc_addr[1:0]),
        .funct3     (acc_funct3),
        .load_data  (load_data),
        .store_word (store_word)
    );

    assign req_ready = (cur_state == ST_IDLE);
    assign rsp_valid = (cur_state == ST_RESP);
    assign state     = cur_state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_state  <= ST_IDLE;
            wait_cnt   <= 4'd0;
            cap_we     <= 1'b0;
            cap_funct3 <= 3'b000;
            cap_addr   <= 32'h0;
            cap_wdata  <= 32'h0;
            rsp_rdata  <= 32'h0;
            rsp_err    <= 1'b0;
        end else begin
            case (cur_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        cap_we     <= req_we;
                        cap_funct3 <= req_funct3;
                        cap_addr   <= req_addr;
                        cap_wdata  <= req_wdata;
                        if (WAIT_CYCLES == 0) begin
                            rsp_rdata <= rdata_next;
                            rsp_err   <= acc_err;
                            cur_state <= ST_RESP;
                        end else begin
                            wait_cnt  <= WAIT_LOAD;
                            cur_state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        rsp_rdata <= rdata_next;
                        rsp_err   <= acc_err;
                        cur_state <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready)
                        cur_state <= ST_IDLE;
                end
                default: cur_state <= ST_IDLE;
            endcase
        end
    end

    // RAM has no reset; the reset_n term keeps a store from landing while
    // reset is held.
    always_ff @(posedge clk) begin
        if (reset_n && commit && acc_we && !acc_err)
            mem[acc_idx] <= store_word;
    end

endmodule
